// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared types and constants for the multi-cycle sequencer
package multicycle_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } halt_cause_t;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - consecutive bus-wait counter with timeout compare
module seq_wait_timer
  import multicycle_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at TIMEOUT; the FSM leaves the wait state on that cycle anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !expired) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == W'(TIMEOUT));

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - fetch/decode/exec/mem/wb control FSM with retire counter
module multicycle_sequencer
  import multicycle_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             imem_req,
  input  logic             imem_ready,
  output logic             ir_we,
  input  logic             dec_reg_write,
  input  logic [2:0]       dec_mem_read,
  input  logic [2:0]       dec_mem_write,
  input  logic             dec_jump,
  input  logic             dec_branch,
  input  logic             dec_illegal,
  input  logic             branch_taken,
  output logic             exec_en,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             halted,
  output logic [1:0]       halt_cause,
  output logic [CNT_W-1:0] instret,
  output logic [2:0]       state
);

  state_t            state_q, state_d;
  halt_cause_t       cause_q, cause_d;
  logic              taken_q, taken_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic              is_load, is_store, taken_now, retire;
  logic              timer_clear, timer_count, timer_expired;

  assign is_load   = |dec_mem_read;
  assign is_store  = |dec_mem_write;
  assign taken_now = dec_jump | (dec_branch & branch_taken);

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    taken_d     = taken_q;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    exec_en     = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    pc_sel      = 1'b0;
    retire      = 1'b0;
    timer_count = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_FETCH;
      ST_FETCH: begin
        imem_req    = 1'b1;
        ir_we       = imem_ready;
        timer_count = !imem_ready;
        if (imem_ready) begin
          state_d = ST_DECODE;
        end else if (timer_expired) begin
          state_d = ST_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        if (dec_illegal) begin
          state_d = ST_HALT;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        exec_en = 1'b1;
        taken_d = taken_now;
        if (is_load || is_store) begin
          state_d = ST_MEM;
        end else if (dec_reg_write) begin
          state_d = ST_WB;
        end else begin
          // Branches retire here, before taken_q has captured the compare.
          retire  = 1'b1;
          pc_sel  = taken_now;
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        dmem_req    = 1'b1;
        dmem_we     = is_store;
        timer_count = !dmem_ready;
        if (dmem_ready) begin
          if (is_load) begin
            state_d = ST_WB;
          end else begin
            retire  = 1'b1;
            pc_sel  = taken_q;
            state_d = ST_FETCH;
          end
        end else if (timer_expired) begin
          state_d = ST_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        retire  = 1'b1;
        pc_sel  = taken_q;
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    pc_we = retire;
  end

  assign instret_d   = retire ? instret_q + CNT_W'(1) : instret_q;
  assign timer_clear = (state_d != state_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
      taken_q   <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      taken_q   <= taken_d;
      instret_q <= instret_d;
    end
  end

  seq_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .count_en (timer_count),
    .expired  (timer_expired)
  );

  assign halted     = (state_q == ST_HALT);
  assign halt_cause = cause_q;
  assign instret    = instret_q;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - directed-vector bench for multicycle_sequencer
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, imem_ready, dmem_ready;
  logic       dec_reg_write, dec_jump, dec_branch, dec_illegal, branch_taken;
  logic [2:0] dec_mem_read, dec_mem_write;
  logic       imem_req, ir_we, exec_en, dmem_req, dmem_we, rf_we, pc_we, pc_sel, halted;
  logic [1:0] halt_cause;
  logic [3:0] instret;
  logic [2:0] state;
  logic [8:0] strobes;
  int         vectors = 0;
  int         miscompares = 0;

  // {imem_req, ir_we, exec_en, dmem_req, dmem_we, rf_we, pc_we, pc_sel, halted}
  localparam logic [8:0] S_NONE = 9'b000000000, S_FETCH = 9'b110000000;
  localparam logic [8:0] S_EXEC = 9'b001000000, S_EXEC_R0 = 9'b001000100, S_EXEC_R1 = 9'b001000110;
  localparam logic [8:0] S_MEM_LD = 9'b000100000, S_MEM_ST = 9'b000110000, S_MEM_ST_R = 9'b000110100;
  localparam logic [8:0] S_WB0 = 9'b000001100, S_WB1 = 9'b000001110, S_HALT = 9'b000000001;

  assign strobes = {imem_req, ir_we, exec_en, dmem_req, dmem_we, rf_we, pc_we, pc_sel, halted};

  always #5 clk = ~clk;

  multicycle_sequencer #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_ready(imem_ready), .ir_we(ir_we),
    .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
    .dec_jump(dec_jump), .dec_branch(dec_branch), .dec_illegal(dec_illegal),
    .branch_taken(branch_taken), .exec_en(exec_en),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .halted(halted), .halt_cause(halt_cause), .instret(instret), .state(state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dec(input logic rw, input logic [2:0] mr, input logic [2:0] mw,
                         input logic j, input logic b, input logic bt, input logic ill);
    dec_reg_write = rw; dec_mem_read = mr; dec_mem_write = mw;
    dec_jump = j; dec_branch = b; branch_taken = bt; dec_illegal = ill;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
    set_dec(1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); step();
    vectors++;
    if ({state, strobes} !== {3'd0, S_NONE}) begin
      miscompares++; $display("FAIL reset_outputs: got %b want %b", {state, strobes}, {3'd0, S_NONE});
    end
    vectors++;
    if ({halt_cause, instret} !== 6'd0) begin
      miscompares++; $display("FAIL reset_cause_instret: got %b want %b", {halt_cause, instret}, 6'd0);
    end
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    logic [11:0] exp [4];
    exp = '{{3'd1, S_FETCH}, {3'd2, S_NONE}, {3'd3, S_EXEC}, {3'd5, S_WB0}};
    set_dec(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({state, strobes} !== exp[i]) begin
        miscompares++; $display("FAIL rtype_cyc%0d: got %b want %b", i, {state, strobes}, exp[i]);
      end
      step();
    end
    vectors++;
    if ({state, instret} !== {3'd1, 4'd1}) begin
      miscompares++; $display("FAIL rtype_instret: got %b want %b", {state, instret}, {3'd1, 4'd1});
    end
  endtask

  task automatic test_load_wait();
    logic [11:0] exp [7];
    exp = '{{3'd1, S_FETCH}, {3'd2, S_NONE}, {3'd3, S_EXEC}, {3'd4, S_MEM_LD},
            {3'd4, S_MEM_LD}, {3'd4, S_MEM_LD}, {3'd5, S_WB0}};
    set_dec(1'b1, 3'b010, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      dmem_ready = (i == 5);
      #1;
      vectors++;
      if ({state, strobes} !== exp[i]) begin
        miscompares++; $display("FAIL load_cyc%0d: got %b want %b", i, {state, strobes}, exp[i]);
      end
      step();
    end
    dmem_ready = 1'b1;
    vectors++;
    if ({state, instret} !== {3'd1, 4'd2}) begin
      miscompares++; $display("FAIL load_instret: got %b want %b", {state, instret}, {3'd1, 4'd2});
    end
  endtask

  task automatic test_store();
    logic [11:0] exp [4];
    exp = '{{3'd1, S_FETCH}, {3'd2, S_NONE}, {3'd3, S_EXEC}, {3'd4, S_MEM_ST_R}};
    set_dec(1'b0, 3'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({state, strobes} !== exp[i]) begin
        miscompares++; $display("FAIL store_cyc%0d: got %b want %b", i, {state, strobes}, exp[i]);
      end
      step();
    end
    vectors++;
    if ({state, instret} !== {3'd1, 4'd3}) begin
      miscompares++; $display("FAIL store_instret: got %b want %b", {state, instret}, {3'd1, 4'd3});
    end
  endtask

  task automatic test_branches();
    for (int t = 1; t >= 0; t--) begin
      set_dec(1'b0, 3'd0, 3'd0, 1'b0, 1'b1, t[0], 1'b0);
      step(); step();
      vectors++;
      if ({state, strobes} !== {3'd3, t[0] ? S_EXEC_R1 : S_EXEC_R0}) begin
        miscompares++; $display("FAIL branch_taken%0d_exec: got %b want %b", t, {state, strobes},
                                {3'd3, t[0] ? S_EXEC_R1 : S_EXEC_R0});
      end
      step();
    end
    vectors++;
    if ({state, instret} !== {3'd1, 4'd5}) begin
      miscompares++; $display("FAIL branch_instret: got %b want %b", {state, instret}, {3'd1, 4'd5});
    end
  endtask

  task automatic test_jal();
    set_dec(1'b1, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(); step(); step();
    vectors++;
    if ({state, strobes} !== {3'd5, S_WB1}) begin
      miscompares++; $display("FAIL jal_wb: got %b want %b", {state, strobes}, {3'd5, S_WB1});
    end
    step();
    vectors++;
    if (instret !== 4'd6) begin
      miscompares++; $display("FAIL jal_instret: got %0d want %0d", instret, 6);
    end
  endtask

  task automatic test_timeout_recover();
    logic [11:0] exp [8];
    exp = '{{3'd1, S_FETCH}, {3'd2, S_NONE}, {3'd3, S_EXEC}, {3'd4, S_MEM_ST},
            {3'd4, S_MEM_ST}, {3'd4, S_MEM_ST}, {3'd4, S_MEM_ST}, {3'd4, S_MEM_ST_R}};
    set_dec(1'b0, 3'd0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      dmem_ready = (i == 7);
      #1;
      vectors++;
      if ({state, strobes} !== exp[i]) begin
        miscompares++; $display("FAIL tmo_recover_cyc%0d: got %b want %b", i, {state, strobes}, exp[i]);
      end
      step();
    end
    dmem_ready = 1'b1;
    vectors++;
    if ({state, instret} !== {3'd1, 4'd7}) begin
      miscompares++; $display("FAIL tmo_recover_instret: got %b want %b", {state, instret}, {3'd1, 4'd7});
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_cnt;
    exp_cnt = 4'd7;
    set_dec(1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(); step(); step();
      exp_cnt = exp_cnt + 4'd1;
      vectors++;
      if (instret !== exp_cnt) begin
        miscompares++; $display("FAIL wrap_retire%0d: got %0d want %0d", k, instret, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_mem();
    set_dec(1'b0, 3'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    dmem_ready = 1'b0;
    step(); step(); step(); step();
    vectors++;
    if ({state, dmem_req} !== {3'd4, 1'b1}) begin
      miscompares++; $display("FAIL midmem_pre: got %b want %b", {state, dmem_req}, {3'd4, 1'b1});
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({state, dmem_req, instret} !== 8'd0) begin
      miscompares++; $display("FAIL midmem_async_reset: got %b want %b", {state, dmem_req, instret}, 8'd0);
    end
    rst = 1'b0;
    dmem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({state, strobes} !== {3'd0, S_NONE}) begin
        miscompares++; $display("FAIL midmem_idle%0d: got %b want %b", i, {state, strobes}, {3'd0, S_NONE});
      end
    end
  endtask

  task automatic test_illegal();
    set_dec(1'b1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    vectors++;
    if ({state, strobes, halt_cause} !== {3'd6, S_HALT, 2'b01}) begin
      miscompares++; $display("FAIL illegal_halt: got %b want %b", {state, strobes, halt_cause}, {3'd6, S_HALT, 2'b01});
    end
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({state, strobes, halt_cause, instret} !== {3'd6, S_HALT, 2'b01, 4'd0}) begin
        miscompares++; $display("FAIL illegal_hold%0d: got %b want %b", i,
                                {state, strobes, halt_cause, instret}, {3'd6, S_HALT, 2'b01, 4'd0});
      end
    end
    start = 1'b0;
  endtask

  task automatic test_timeout_halt();
    rst = 1'b1;
    step();
    rst = 1'b0;
    set_dec(1'b0, 3'd0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    dmem_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if ({state, strobes} !== {3'd4, S_MEM_ST}) begin
        miscompares++; $display("FAIL tmo_mem%0d: got %b want %b", i, {state, strobes}, {3'd4, S_MEM_ST});
      end
    end
    step();
    vectors++;
    if ({state, strobes, halt_cause} !== {3'd6, S_HALT, 2'b10}) begin
      miscompares++; $display("FAIL tmo_halt: got %b want %b", {state, strobes, halt_cause}, {3'd6, S_HALT, 2'b10});
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_wait();
    test_store();
    test_branches();
    test_jal();
    test_timeout_recover();
    test_wrap();
    test_reset_mid_mem();
    test_illegal();
    test_timeout_halt();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
